// File: rtl/if_stage_bp.sv
// Instruction-fetch stage with PC register, immediate extraction and a 2-bit BHT branch predictor.
// Optional return-address stack enabled by defining IF_RAS_EN.
module if_stage_bp #(
    parameter int              size      = 32,
    parameter int              BHT_DEPTH = 64,
    parameter logic [size-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            buble,
    input  logic [size-1:0] instruction_i,
    input  logic            isValid,
    input  logic [size-1:0] Correct_PC,
    input  logic            upd_valid,
    input  logic [size-1:0] upd_pc,
    input  logic            upd_taken,
    output logic [size-1:0] instruction_o,
    output logic [size-1:0] ins_address,
    output logic [size-1:0] IMM,
    output logic [size-1:0] PCplus,
    output logic            Predicted_MPC,
    output logic [size-1:0] pred_target
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [size-1:0]  pc_q;
    logic [1:0]       bht [BHT_DEPTH];
    logic [6:0]       opcode;
    logic             is_jal, is_branch, is_jalr;
    logic signed [31:0] imm_sel;
    logic [size-1:0]  branch_target;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             unused_upd_bits;

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    assign opcode    = instruction_i[6:0];
    assign is_jal    = (opcode == 7'b1101111);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jalr   = (opcode == 7'b1100111);

    assign rd_idx = pc_q[IDX_W+1:2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign unused_upd_bits = ^{upd_pc[size-1:IDX_W+2], upd_pc[1:0]};

    always_comb begin
        imm_sel = '0;
        if (is_jal)
            imm_sel = {{12{instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
                       instruction_i[30:21], 1'b0};
        else if (is_branch)
            imm_sel = {{20{instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                       instruction_i[11:8], 1'b0};
        else if (is_jalr)
            imm_sel = {{21{instruction_i[31]}}, instruction_i[30:20]};
    end

    assign IMM           = size'(imm_sel);
    assign instruction_o = instruction_i;
    assign ins_address   = pc_q;
    assign PCplus        = pc_q + size'(4);
    assign branch_target = pc_q + IMM;

`ifdef IF_RAS_EN
    localparam int RAS_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [size-1:0] ras [RAS_DEPTH];
    logic [RAS_W-1:0] ras_sp;
    logic [RAS_W:0]   ras_cnt;
    logic             rd_link, rs1_link, ras_push, ras_pop, ras_upd;

    assign rd_link  = (instruction_i[11:7] == 5'd1) || (instruction_i[11:7] == 5'd5);
    assign rs1_link = (instruction_i[19:15] == 5'd1) || (instruction_i[19:15] == 5'd5);
    assign ras_push = (is_jal || is_jalr) && rd_link;
    assign ras_pop  = is_jalr && rs1_link && (ras_cnt != '0);
    assign ras_upd  = !buble && !isValid;

    // Pointer and occupancy are control state; pop-then-push rewrites the top in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_sp  <= '0;
            ras_cnt <= '0;
        end else if (ras_upd) begin
            if (ras_pop && !ras_push) begin
                ras_sp  <= ras_sp - RAS_W'(1);
                ras_cnt <= ras_cnt - (RAS_W+1)'(1);
            end else if (ras_push && !ras_pop) begin
                ras_sp  <= ras_sp + RAS_W'(1);
                if (ras_cnt != (RAS_W+1)'(RAS_DEPTH))
                    ras_cnt <= ras_cnt + (RAS_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ras_upd) begin
            if (ras_pop && ras_push)
                ras[ras_sp] <= PCplus;
            else if (ras_push)
                ras[ras_sp + RAS_W'(1)] <= PCplus;
        end
    end
`endif

    always_comb begin
        Predicted_MPC = 1'b0;
        pred_target   = PCplus;
        if (is_jal || (is_branch && bht[rd_idx][1])) begin
            Predicted_MPC = 1'b1;
            pred_target   = branch_target;
        end
`ifdef IF_RAS_EN
        else if (ras_pop) begin
            Predicted_MPC = 1'b1;
            pred_target   = ras[ras_sp];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= RESET_PC;
        else if (isValid)
            pc_q <= Correct_PC;
        else if (!buble)
            pc_q <= pred_target;
    end

    // Training is independent of stalls/redirects; the new count is visible next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= 2'b01;
        end else if (upd_valid) begin
            bht[wr_idx] <= bht_next(bht[wr_idx], upd_taken);
        end
    end
endmodule
